// File: rtl/universal_reg_async_low_if.sv
// Bus interface for universal_reg_async_low: control/data inputs and register outputs.
// clk and the active-low reset stay as plain ports on the register itself.
interface universal_reg_async_low_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             sout_l;
    logic             sout_r;
    logic             tc;

    modport master (
        output en, mode, d, sin_l, sin_r,
        input  q, q_bar, sout_l, sout_r, tc
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r,
        output q, q_bar, sout_l, sout_r, tc
    );
endinterface

// File: rtl/universal_reg_async_low.sv
// Universal WIDTH-bit register: hold, load, shift, rotate and up/down count,
// with a terminal-count flag and an asynchronous active-low reset to RST_VAL.
// Each bit is its own DFF cell (clear or preset chosen from RST_VAL) fed by an
// 8:1 next-state mux plus an enable mux; count carry/borrow ripples across bits.
module universal_reg_async_low #(
    parameter int unsigned WIDTH   = 8,
    parameter logic [63:0] RST_VAL = 64'd0
) (
    input  logic                    clk,
    input  logic                    r,
    universal_reg_async_low_if.slave bus
);

    localparam logic [WIDTH-1:0] L_RST_VAL = WIDTH'(RST_VAL);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_UP   = 3'b110;
    localparam logic [2:0] MODE_DOWN = 3'b111;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_shiftLeft;
    logic [WIDTH-1:0] w_shiftRight;
    logic [WIDTH-1:0] w_rotLeft;
    logic [WIDTH-1:0] w_rotRight;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH:0]   w_borrow;

    assign w_shiftLeft  = {w_q[WIDTH-2:0], bus.sin_l};
    assign w_shiftRight = {bus.sin_r, w_q[WIDTH-1:1]};
    assign w_rotLeft    = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
    assign w_rotRight   = {w_q[0], w_q[WIDTH-1:1]};

    // Ripple chain seeds: adding one / subtracting one always toggles bit 0.
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic r_bit;
        logic w_sel;
        logic w_d;

        assign w_carry[i+1]  = w_carry[i] & w_q[i];
        assign w_borrow[i+1] = w_borrow[i] & ~w_q[i];
        assign w_inc[i]      = w_q[i] ^ w_carry[i];
        assign w_dec[i]      = w_q[i] ^ w_borrow[i];

        // Per-bit 8:1 next-state mux selected by mode, then the enable feedback mux.
        always_comb begin
            w_sel = w_q[i];
            case (bus.mode)
                MODE_HOLD: w_sel = w_q[i];
                MODE_LOAD: w_sel = bus.d[i];
                MODE_SHL:  w_sel = w_shiftLeft[i];
                MODE_SHR:  w_sel = w_shiftRight[i];
                MODE_ROL:  w_sel = w_rotLeft[i];
                MODE_ROR:  w_sel = w_rotRight[i];
                MODE_UP:   w_sel = w_inc[i];
                MODE_DOWN: w_sel = w_dec[i];
                default:   w_sel = w_q[i];
            endcase
            w_d = bus.en ? w_sel : r_bit;
        end

        // Storage cell: async clear or preset to this bit of RST_VAL, else capture.
        always_ff @(posedge clk or negedge r) begin
            if (!r) begin
                r_bit <= L_RST_VAL[i];
            end else begin
                r_bit <= w_d;
            end
        end

        assign w_q[i] = r_bit;
    end

    assign bus.q      = w_q;
    assign bus.q_bar  = ~w_q;
    assign bus.sout_l = w_q[WIDTH-1];
    assign bus.sout_r = w_q[0];

    // Ripple chain outputs double as the all-ones / all-zeros detectors.
    assign bus.tc = ((bus.mode == MODE_UP)   && w_carry[WIDTH]) ||
                    ((bus.mode == MODE_DOWN) && w_borrow[WIDTH]);

endmodule
